pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
Central stall/flush scheduler for the 5-stage pipeline. It arbitrates stop requests from ID, EX and MEM into the shared 6-bit stop_all bus, which the PC and every pipeline register (IF/ID … MEM/WB) consume. It sequences exception flushes and redirects the PC. A watchdog converts a memory stall that never ends into a bus-timeout flush. It also keeps a saturating stall-cycle performance counter.

Parameters:
STALL_TIMEOUT, 1024, consecutive MEM-stall cycles before the watchdog fires (must be ≥2)
TIMEOUT_VECTOR, 32'h0000_0040, PC loaded on watchdog flush
FLUSH_MASK_CYCLES, 1, cycles after a flush during which ID/EX stop requests are ignored (stale); range 1..7

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high (`ResetEnable)
stop_request_from_id  in  1  ID-stage stall request
stop_request_from_ex  in  1  EX-stage stall request (multi-cycle mul/div)
stop_request_from_mem  in  1  MEM-stage stall request (bus wait)
flush_request  in  1  exception flush from MEM stage
exception_vector_input  in  32  handler PC for flush_request
perf_clear  in  1  synchronous clear of stall_cycle_count
stop_all  out  6  [0]=PC [1]=IF/ID [2]=ID/EX [3]=EX/MEM [4]=MEM/WB [5]=WB; 1=`Stop
flush  out  1  flush all pipeline registers this cycle
new_pc  out  32  PC target, valid when flush=1
timeout_exception_output  out  1  one-cycle pulse coincident with watchdog flush
stall_cycle_count  out  32  saturating count of cycles with stop_all≠0

Behaviour:
- States: RUN, STALL, TIMEOUT, HOLDOFF. State and counters are registered. stop_all, flush and new_pc are combinational (Mealy) so stages see them the same cycle.
- Reset (clock edge with reset=1): state=RUN, watchdog=0, holdoff=0, stall_cycle_count=0. While reset=1 all outputs are forced 0.
- stop_all encoding, priority MEM > EX > ID:
  - MEM request → 6'b011111
  - EX request → 6'b001111
  - ID request → 6'b000111
  - none → 6'b000000
  - Bit 5 is never asserted; MEM/WB therefore inserts a bubble on MEM stalls.
- flush_request has priority over all stop requests in RUN, STALL and HOLDOFF:
  - flush=1, new_pc=exception_vector_input, stop_all=0.
  - Next state is HOLDOFF with holdoff counter=FLUSH_MASK_CYCLES.
- RUN:
  - Any stop request → stop_all per encoding.
  - Next state is STALL if any request, else RUN.
- STALL:
  - stop_all per encoding.
  - Watchdog increments each cycle stop_request_from_mem=1 and clears when it is 0.
  - When the watchdog reaches STALL_TIMEOUT → TIMEOUT on the next edge.
  - When no request remains → RUN and watchdog=0.
- TIMEOUT (exactly one cycle, requests ignored):
  - flush=1, new_pc=TIMEOUT_VECTOR, timeout_exception_output=1, stop_all=0.
  - Watchdog=0; next state HOLDOFF.
- HOLDOFF:
  - ID/EX requests are masked; MEM requests are honoured (6'b011111), and the watchdog counts them.
  - Holdoff decrements each cycle; at 0 → RUN, or STALL if a request is present.
  - A flush_request arriving in HOLDOFF restarts HOLDOFF.
- flush_request and the watchdog expiring in the same cycle: flush_request wins, exception_vector_input is used, and no timeout pulse is issued.
- stall_cycle_count:
  - +1 on each cycle stop_all≠0; saturates at 32'hFFFF_FFFF (no wrap).
  - perf_clear overrides increment (result 0).
- new_pc = 0 when flush=0.

Decomposition:
- Shared defines:
  - `Stop/`NoStop
  - `StopAllBus [5:0]
  - stall encodings STALL_FROM_ID/EX/MEM
  - `ZeroWord
  - state encodings for RUN/STALL/TIMEOUT/HOLDOFF
- One natural sub-module: stall_watchdog (counter, clear, expiry flag, parameterised STALL_TIMEOUT).

Test Plan:
- ID request 1 cycle then EX 3 cycles → stop_all=6'b000111 then 6'b001111 ×3, then 0; stall_cycle_count=4.
- ID+EX+MEM asserted together for 2 cycles → stop_all=6'b011111 both cycles (MEM priority).
- Flush while EX stalls, vector 32'h0000_0020 → same cycle flush=1, new_pc=32'h20, stop_all=0. Next cycle EX request masked: stop_all=0 with FLUSH_MASK_CYCLES=1.
- STALL_TIMEOUT=4, MEM request held high → 4 cycles of 6'b011111, then one cycle flush=1, new_pc=32'h40, timeout_exception_output=1, then HOLDOFF.
- flush_request on the watchdog-expiry cycle → new_pc=exception_vector_input, timeout_exception_output=0.
- Reset asserted mid-STALL → next edge all outputs 0 and state RUN. Preload count near saturation, then stall → count holds at 32'hFFFF_FFFF. perf_clear → 0.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared stop-bus encodings, FSM state codes and the stop-priority helper
// for the pipeline stall/flush scheduler.
package pipeline_stall_ctrl_pkg;

    localparam int STOP_ALL_W = 6;
    typedef logic [STOP_ALL_W-1:0] stop_all_bus_t;

    localparam stop_all_bus_t STALL_NONE     = 6'b000000;
    localparam stop_all_bus_t STALL_FROM_ID  = 6'b000111;
    localparam stop_all_bus_t STALL_FROM_EX  = 6'b001111;
    localparam stop_all_bus_t STALL_FROM_MEM = 6'b011111;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_STALL   = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    localparam logic [1:0] ST_HOLDOFF = 2'd3;

    // MEM outranks EX outranks ID; the WB bit is never driven so MEM/WB bubbles.
    function automatic stop_all_bus_t stop_encode(input logic mem, input logic ex, input logic id);
        stop_all_bus_t bus;
        bus = STALL_NONE;
        if (mem) begin
            bus = STALL_FROM_MEM;
        end else if (ex) begin
            bus = STALL_FROM_EX;
        end else if (id) begin
            bus = STALL_FROM_ID;
        end
        return bus;
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_watchdog.sv
// Counts consecutive honoured MEM-stall cycles; expire is combinational and
// marks the cycle whose increment reaches STALL_TIMEOUT.
module pipeline_stall_ctrl_watchdog #(
    parameter int unsigned STALL_TIMEOUT = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic mem_stall,
    output logic expire
);

    localparam int unsigned W = $clog2(STALL_TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(STALL_TIMEOUT - 1);

    logic [W-1:0] wd_q;
    logic [W-1:0] wd_d;

    always_comb begin
        expire = mem_stall && (wd_q == LAST);
        wd_d   = '0;
        // Any gap in the MEM request restarts the count; expiry hands over to the FSM.
        if (mem_stall && !expire) begin
            wd_d = wd_q + W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush scheduler: merges ID/EX/MEM stop requests onto stop_all, sequences
// exception and watchdog flushes; all outputs are same-cycle (Mealy) from registered state.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int unsigned STALL_TIMEOUT     = 1024,
    parameter logic [31:0] TIMEOUT_VECTOR    = 32'h0000_0040,
    parameter int unsigned FLUSH_MASK_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stop_request_from_id,
    input  logic        stop_request_from_ex,
    input  logic        stop_request_from_mem,
    input  logic        flush_request,
    input  logic [31:0] exception_vector_input,
    input  logic        perf_clear,
    output logic [5:0]  stop_all,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        timeout_exception_output,
    output logic [31:0] stall_cycle_count
);

    localparam logic [2:0] HOLDOFF_INIT = 3'(FLUSH_MASK_CYCLES);

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [2:0]    holdoff_q;
    logic [2:0]    holdoff_d;
    logic [31:0]   stall_cycle_count_q;
    logic [31:0]   stall_cycle_count_d;

    stop_all_bus_t stop_bus;
    logic          flush_int;
    logic [31:0]   pc_int;
    logic          timeout_int;
    logic          mask_id_ex;
    logic          any_req;
    logic          wd_inc;
    logic          wd_expire;

    assign mask_id_ex = (state_q == ST_HOLDOFF);
    assign any_req    = stop_request_from_mem | stop_request_from_ex | stop_request_from_id;

    // The watchdog only sees MEM stalls that actually reach the stop bus.
    assign wd_inc = stop_request_from_mem && (state_q != ST_TIMEOUT) && !flush_request;

    pipeline_stall_ctrl_watchdog #(
        .STALL_TIMEOUT(STALL_TIMEOUT)
    ) u_stall_watchdog (
        .clock    (clock),
        .reset    (reset),
        .mem_stall(wd_inc),
        .expire   (wd_expire)
    );

    always_comb begin
        stop_bus    = STALL_NONE;
        flush_int   = 1'b0;
        pc_int      = ZERO_WORD;
        timeout_int = 1'b0;
        state_d     = state_q;
        holdoff_d   = holdoff_q;

        if (state_q == ST_TIMEOUT) begin
            flush_int   = 1'b1;
            pc_int      = TIMEOUT_VECTOR;
            timeout_int = 1'b1;
            state_d     = ST_HOLDOFF;
            holdoff_d   = HOLDOFF_INIT;
        end else if (flush_request) begin
            flush_int = 1'b1;
            pc_int    = exception_vector_input;
            state_d   = ST_HOLDOFF;
            holdoff_d = HOLDOFF_INIT;
        end else begin
            stop_bus = stop_encode(stop_request_from_mem,
                                   stop_request_from_ex & ~mask_id_ex,
                                   stop_request_from_id & ~mask_id_ex);
            if (state_q == ST_HOLDOFF) begin
                holdoff_d = holdoff_q - 3'd1;
                if (holdoff_q == 3'd1) begin
                    state_d = any_req ? ST_STALL : ST_RUN;
                end
            end else begin
                state_d = any_req ? ST_STALL : ST_RUN;
            end
            if (wd_expire) begin
                state_d   = ST_TIMEOUT;
                holdoff_d = 3'd0;
            end
        end
    end

    always_comb begin
        stall_cycle_count_d = stall_cycle_count_q;
        if (perf_clear) begin
            stall_cycle_count_d = ZERO_WORD;
        end else if ((stop_bus != STALL_NONE) && (stall_cycle_count_q != 32'hFFFF_FFFF)) begin
            stall_cycle_count_d = stall_cycle_count_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q             <= ST_RUN;
            holdoff_q           <= 3'd0;
            stall_cycle_count_q <= ZERO_WORD;
        end else begin
            state_q             <= state_d;
            holdoff_q           <= holdoff_d;
            stall_cycle_count_q <= stall_cycle_count_d;
        end
    end

    assign stop_all                 = reset ? STALL_NONE : stop_bus;
    assign flush                    = reset ? 1'b0 : flush_int;
    assign new_pc                   = reset ? ZERO_WORD : pc_int;
    assign timeout_exception_output = reset ? 1'b0 : timeout_int;
    assign stall_cycle_count        = reset ? ZERO_WORD : stall_cycle_count_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: rule-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pipeline_stall_ctrl;

    localparam int unsigned TO   = 4;
    localparam logic [31:0] TV   = 32'h0000_0040;
    localparam int unsigned MASK = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        id = 1'b0;
    logic        ex = 1'b0;
    logic        mem = 1'b0;
    logic        flush_request = 1'b0;
    logic [31:0] vec = 32'h0;
    logic        perf_clear = 1'b0;
    logic [5:0]  stop_all;
    logic        flush;
    logic [31:0] new_pc;
    logic        to_pulse;
    logic [31:0] cnt;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // model: mode 0 = normal, 1 = timeout cycle pending, 2 = holdoff
    int          m_mode = 0;
    int          m_hold = 0;
    int          m_wd   = 0;
    logic [31:0] m_cnt  = 32'h0;

    logic [5:0]  s_stop;
    logic        s_flush;
    logic        s_to;
    logic [31:0] s_pc;
    logic [31:0] s_cnt;

    always #5 clock = ~clock;

    pipeline_stall_ctrl #(
        .STALL_TIMEOUT    (TO),
        .TIMEOUT_VECTOR   (TV),
        .FLUSH_MASK_CYCLES(MASK)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .stop_request_from_id    (id),
        .stop_request_from_ex    (ex),
        .stop_request_from_mem   (mem),
        .flush_request           (flush_request),
        .exception_vector_input  (vec),
        .perf_clear              (perf_clear),
        .stop_all                (stop_all),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .timeout_exception_output(to_pulse),
        .stall_cycle_count       (cnt)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    task automatic cycle();
        logic [5:0]  e_stop;
        logic        e_flush;
        logic        e_to;
        logic [31:0] e_pc;
        @(negedge clock);
        e_stop  = 6'b0;
        e_flush = 1'b0;
        e_to    = 1'b0;
        e_pc    = 32'h0;
        if (!reset) begin
            if (m_mode == 1) begin
                e_flush = 1'b1;
                e_pc    = TV;
                e_to    = 1'b1;
            end else if (flush_request) begin
                e_flush = 1'b1;
                e_pc    = vec;
            end else if (mem) begin
                e_stop = 6'b011111;
            end else if (m_mode != 2 && ex) begin
                e_stop = 6'b001111;
            end else if (m_mode != 2 && id) begin
                e_stop = 6'b000111;
            end
        end
        s_stop  = stop_all;
        s_flush = flush;
        s_to    = to_pulse;
        s_pc    = new_pc;
        s_cnt   = cnt;
        chk("stop_all", 32'(stop_all), 32'(e_stop));
        chk("flush", 32'(flush), 32'(e_flush));
        chk("new_pc", new_pc, e_pc);
        chk("timeout_pulse", 32'(to_pulse), 32'(e_to));
        chk("stall_count", cnt, reset ? 32'h0 : m_cnt);
        if (reset) begin
            m_mode = 0;
            m_hold = 0;
            m_wd   = 0;
            m_cnt  = 32'h0;
        end else begin
            if (perf_clear) m_cnt = 32'h0;
            else if (e_stop != 6'b0 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (m_mode == 1 || flush_request) begin
                m_mode = 2;
                m_hold = MASK;
                m_wd   = 0;
            end else begin
                m_wd = mem ? m_wd + 1 : 0;
                if (m_mode == 2) begin
                    m_hold = m_hold - 1;
                    if (m_hold == 0) m_mode = 0;
                end
                if (m_wd == TO) begin
                    m_mode = 1;
                    m_wd   = 0;
                end
            end
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        id = 1'b0; ex = 1'b0; mem = 1'b0; flush_request = 1'b0; perf_clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        cycle();
        chk("reset_stop", 32'(s_stop), 32'h0);
        chk("reset_flush", 32'(s_flush), 32'h0);
        cycle();
        reset = 1'b0;
        cycle();
        chk("count_after_reset", s_cnt, 32'h0);

        // ID for one cycle, then EX for three
        id = 1'b1;
        cycle();
        chk("id_stop", 32'(s_stop), 32'h07);
        id = 1'b0; ex = 1'b1;
        repeat (3) begin
            cycle();
            chk("ex_stop", 32'(s_stop), 32'h0F);
        end
        ex = 1'b0;
        cycle();
        chk("idle_stop", 32'(s_stop), 32'h00);
        chk("count_four", s_cnt, 32'd4);

        // all three together: MEM wins
        id = 1'b1; ex = 1'b1; mem = 1'b1;
        repeat (2) begin
            cycle();
            chk("mem_priority", 32'(s_stop), 32'h1F);
        end
        idle_inputs();
        cycle();

        // exception flush during an EX stall, then stale EX masked
        ex = 1'b1;
        cycle();
        flush_request = 1'b1; vec = 32'h0000_0020;
        cycle();
        chk("flush_flag", 32'(s_flush), 32'h1);
        chk("flush_pc", s_pc, 32'h0000_0020);
        chk("flush_stop", 32'(s_stop), 32'h0);
        flush_request = 1'b0;
        cycle();
        chk("holdoff_mask", 32'(s_stop), 32'h0);
        chk("holdoff_noflush", 32'(s_flush), 32'h0);
        cycle();
        chk("after_holdoff", 32'(s_stop), 32'h0F);
        idle_inputs();
        cycle();

        // watchdog expiry
        mem = 1'b1;
        repeat (4) begin
            cycle();
            chk("mem_stall", 32'(s_stop), 32'h1F);
        end
        cycle();
        chk("wd_flush", 32'(s_flush), 32'h1);
        chk("wd_pc", s_pc, 32'h0000_0040);
        chk("wd_pulse", 32'(s_to), 32'h1);
        chk("wd_stop", 32'(s_stop), 32'h0);
        cycle();
        chk("holdoff_mem", 32'(s_stop), 32'h1F);
        idle_inputs();
        repeat (2) cycle();

        // flush on the expiry cycle wins
        mem = 1'b1;
        repeat (3) cycle();
        flush_request = 1'b1; vec = 32'h1234_5678;
        cycle();
        chk("race_pc", s_pc, 32'h1234_5678);
        chk("race_pulse", 32'(s_to), 32'h0);
        chk("race_flush", 32'(s_flush), 32'h1);
        idle_inputs();
        cycle();
        chk("race_no_late_pulse", 32'(s_to), 32'h0);
        chk("race_no_late_flush", 32'(s_flush), 32'h0);
        cycle();

        // reset in the middle of a stall
        ex = 1'b1;
        repeat (2) cycle();
        reset = 1'b1;
        cycle();
        chk("rst_mid_stop", 32'(s_stop), 32'h0);
        chk("rst_mid_cnt", s_cnt, 32'h0);
        reset = 1'b0; ex = 1'b0;
        cycle();
        chk("rst_after_stop", 32'(s_stop), 32'h0);
        chk("rst_after_cnt", s_cnt, 32'h0);

        // saturation of the performance counter, then clear
        force dut.stall_cycle_count_q = 32'hFFFF_FFFD;
        m_cnt = 32'hFFFF_FFFD;
        cycle();
        release dut.stall_cycle_count_q;
        id = 1'b1;
        repeat (4) cycle();
        chk("count_saturated", s_cnt, 32'hFFFF_FFFF);
        perf_clear = 1'b1;
        cycle();
        perf_clear = 1'b0;
        cycle();
        chk("count_cleared", s_cnt, 32'h0);
        idle_inputs();
        cycle();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 4) == 0) mem = ~mem;
            if ($urandom_range(0, 2) == 0) ex = ($urandom_range(0, 1) == 0);
            id            = ($urandom_range(0, 3) == 0);
            flush_request = ($urandom_range(0, 29) == 0);
            vec           = $urandom;
            perf_clear    = ($urandom_range(0, 99) == 0);
            reset         = ($urandom_range(0, 199) == 0);
            cycle();
        end
        reset = 1'b0;
        idle_inputs();
        repeat (4) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
